pc_sequencer: RTL and testbench

Sequencing controller for the program counter. Owns the PC register and decides each cycle whether the PC takes the NPC result (`next_pc`), holds (stall/halt), jumps to an interrupt vector, or returns from an interrupt via the saved EPC. Sits between the NPC logic and the instruction-memory address port.

Addresses are word addresses, and the sequential successor is `PC+1`.

---
 rtl/pc_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_pc_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter and picks, every cycle, between the
// NPC result, a hold (stall/halt), an interrupt vector, or an exception
// return through the saved EPC.
// Optional build macro: PC_SEQ_INT_NEST_EN enables nested interrupts
// (3-deep EPC stack plus a current-level register). When it is undefined,
// one EPC register is used and interrupts are taken only from RUN.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] VEC0     = 32'h0000_0100,
  parameter logic [31:0] VEC1     = 32'h0000_0200,
  parameter logic [31:0] VEC2     = 32'h0000_0300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  input  logic        redirect,
  input  logic        stall,
  input  logic        halt,
  input  logic        go,
  input  logic [2:0]  irq,
  input  logic        eret,
  output logic [31:0] pc,
  output logic        flush,
  output logic [2:0]  int_ack,
  output logic        in_service,
  output logic        halted
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_ISR  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [1:0]  ret_state;
  logic [1:0]  ret_state_next;
  logic [31:0] pc_next;
  logic [31:0] ret_addr;
  logic [2:0]  irq_q;
  logic [2:0]  pend;
  logic [2:0]  pend_next;
  logic [2:0]  pend_rise;
  logic [2:0]  win_onehot;
  logic [31:0] win_vec;
  logic [2:0]  ack_mask;
  logic        flush_next;
  logic        in_service_next;
  logic        halted_next;
  logic        last_level;
  logic        preempt_ok;
  logic        do_vector;

  assign pend_rise = irq & ~irq_q;

`ifdef PC_SEQ_INT_NEST_EN
  // Return addresses and the level each one interrupted, indexed by depth.
  logic [31:0] epc_stk [0:2];
  logic [1:0]  lvl_stk [0:2];
  logic [1:0]  cur_lvl;
  logic [1:0]  sp;
  logic [1:0]  top;
  logic [1:0]  win_lvl;
  logic        pop;

  assign top        = sp - 2'd1;
  assign ret_addr   = epc_stk[top];
  assign last_level = (sp == 2'd1);
  assign win_lvl    = pend[0] ? 2'd0 : (pend[1] ? 2'd1 : 2'd2);
  // cur_lvl is 3 outside any handler, so nothing is ever masked in RUN.
  assign preempt_ok = (win_lvl < cur_lvl);
  // ISR excludes HALT, so only halt can outrank an eret here.
  assign pop        = (state == ST_ISR) && !halt && eret;

  // Push on every accepted interrupt, pop on every eret taken in ISR.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp      <= 2'd0;
      cur_lvl <= 2'd3;
      for (int i = 0; i < 3; i++) begin
        epc_stk[i] <= 32'h0;
        lvl_stk[i] <= 2'd3;
      end
    end else if (do_vector) begin
      epc_stk[sp] <= next_pc;
      lvl_stk[sp] <= cur_lvl;
      sp          <= sp + 2'd1;
      cur_lvl     <= win_lvl;
    end else if (pop) begin
      sp      <= top;
      cur_lvl <= lvl_stk[top];
    end
  end
`else
  logic [31:0] epc;

  assign ret_addr   = epc;
  assign last_level = 1'b1;
  assign preempt_ok = 1'b0;

  // Single return address, captured when an interrupt is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      epc <= 32'h0;
    end else if (do_vector) begin
      epc <= next_pc;
    end
  end
`endif

  // Fixed priority: the lowest-index pending request wins.
  always_comb begin
    win_onehot = 3'b000;
    win_vec    = VEC0;
    if (pend[0]) begin
      win_onehot = 3'b001;
      win_vec    = VEC0;
    end else if (pend[1]) begin
      win_onehot = 3'b010;
      win_vec    = VEC1;
    end else if (pend[2]) begin
      win_onehot = 3'b100;
      win_vec    = VEC2;
    end
  end

  // Per-cycle sequencing decision: halt > eret > interrupt > stall > normal.
  always_comb begin
    pc_next         = pc;
    state_next      = state;
    ret_state_next  = ret_state;
    flush_next      = 1'b0;
    ack_mask        = 3'b000;
    in_service_next = in_service;
    halted_next     = halted;
    do_vector       = 1'b0;
    if (state == ST_HALT) begin
      // Held pc is the resume address; halt is ignored while halted.
      if (go) begin
        state_next  = ret_state;
        halted_next = 1'b0;
      end
    end else if (halt) begin
      pc_next        = next_pc;
      ret_state_next = state;
      state_next     = ST_HALT;
      halted_next    = 1'b1;
    end else if (eret && (state == ST_ISR)) begin
      pc_next    = ret_addr;
      flush_next = 1'b1;
      if (last_level) begin
        state_next      = ST_RUN;
        in_service_next = 1'b0;
      end
    end else if (!stall && (pend != 3'b000) &&
                 ((state == ST_RUN) || ((state == ST_ISR) && preempt_ok))) begin
      do_vector       = 1'b1;
      pc_next         = win_vec;
      ack_mask        = win_onehot;
      flush_next      = 1'b1;
      state_next      = ST_ISR;
      in_service_next = 1'b1;
    end else if (!stall) begin
      pc_next    = next_pc;
      flush_next = redirect;
    end
    // A fresh edge on the bit being acknowledged keeps it pending.
    pend_next = (pend & ~ack_mask) | pend_rise;
  end

  // Architectural registers; every output is driven straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      state      <= ST_RUN;
      ret_state  <= ST_RUN;
      irq_q      <= 3'b000;
      pend       <= 3'b000;
      flush      <= 1'b0;
      int_ack    <= 3'b000;
      in_service <= 1'b0;
      halted     <= 1'b0;
    end else begin
      pc         <= pc_next;
      state      <= state_next;
      ret_state  <= ret_state_next;
      irq_q      <= irq;
      pend       <= pend_next;
      flush      <= flush_next;
      int_ack    <= ack_mask;
      in_service <= in_service_next;
      halted     <= halted_next;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios with fixed expected values,
// then randomized traffic checked against a queue-based reference model.
// Honors PC_SEQ_INT_NEST_EN the same way the design does.
`timescale 1ns/1ps
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] VEC0     = 32'h0000_0100;
  localparam logic [31:0] VEC1     = 32'h0000_0200;
  localparam logic [31:0] VEC2     = 32'h0000_0300;
`ifdef PC_SEQ_INT_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif
  localparam int M_RUN = 0, M_ISR = 1, M_HALT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] next_pc = 32'h0;
  logic        redirect = 1'b0;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        go = 1'b0;
  logic [2:0]  irq = 3'b000;
  logic        eret = 1'b0;
  logic [31:0] pc;
  logic        flush;
  logic [2:0]  int_ack;
  logic        in_service;
  logic        halted;

  int checks = 0;
  int failures = 0;

  pc_sequencer #(
    .RESET_PC(RESET_PC), .VEC0(VEC0), .VEC1(VEC1), .VEC2(VEC2)
  ) dut (
    .clk(clk), .rst(rst), .next_pc(next_pc), .redirect(redirect),
    .stall(stall), .halt(halt), .go(go), .irq(irq), .eret(eret),
    .pc(pc), .flush(flush), .int_ack(int_ack), .in_service(in_service),
    .halted(halted)
  );

  always #5 clk = ~clk;

  // Reference model: mode, pending set, and a return stack of (addr, level).
  logic [31:0] m_pc;
  int          m_mode;
  int          m_ret;
  logic [2:0]  m_pend;
  logic [2:0]  m_irq_q;
  logic [2:0]  m_ack;
  logic        m_flush;
  logic [31:0] m_epc[$];
  int          m_lvl[$];

  function automatic logic [31:0] vec_of(int k);
    if (k == 0) return VEC0;
    if (k == 1) return VEC1;
    return VEC2;
  endfunction

  task automatic model_step();
    logic [2:0] rise;
    int k;
    rise = irq & ~m_irq_q;
    m_flush = 1'b0;
    m_ack = 3'b000;
    if (rst) begin
      m_pc = RESET_PC; m_mode = M_RUN; m_ret = M_RUN;
      m_pend = 3'b000; m_irq_q = 3'b000;
      m_epc.delete(); m_lvl.delete();
      return;
    end
    k = 3;
    for (int i = 2; i >= 0; i--) if (m_pend[i]) k = i;
    if (m_mode == M_HALT) begin
      if (go) m_mode = m_ret;
    end else if (halt) begin
      m_pc = next_pc; m_ret = m_mode; m_mode = M_HALT;
    end else if (eret && m_mode == M_ISR) begin
      m_pc = m_epc.pop_back();
      void'(m_lvl.pop_back());
      if (m_epc.size() == 0) m_mode = M_RUN;
      m_flush = 1'b1;
    end else if (!stall && k < 3 &&
                 (m_mode == M_RUN || (NEST && m_mode == M_ISR && k < m_lvl[$]))) begin
      m_epc.push_back(next_pc);
      m_lvl.push_back(k);
      m_pc = vec_of(k);
      m_pend[k] = 1'b0;
      m_ack = 3'b001 << k;
      m_mode = M_ISR;
      m_flush = 1'b1;
    end else if (!stall) begin
      m_pc = next_pc;
      m_flush = redirect;
    end
    m_pend = m_pend | rise;
    m_irq_q = irq;
  endtask

  // One clock: model follows the edge, outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; next_pc = 32'h1234; irq = 3'b000;
    tick(); tick();
    checks++; if (pc !== RESET_PC) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, RESET_PC); end
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", flush); end
    checks++; if (int_ack !== 3'b000) begin failures++; $display("FAIL reset_ack got=%b exp=000", int_ack); end
    checks++; if (in_service !== 1'b0) begin failures++; $display("FAIL reset_in_service got=%b exp=0", in_service); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
    rst = 1'b0;
    $display("test_reset: pc=%h", pc);
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 4; i++) begin
      checks++; if (pc !== 32'(i)) begin failures++; $display("FAIL free_run_pc got=%h exp=%h", pc, 32'(i)); end
      checks++; if (flush !== 1'b0) begin failures++; $display("FAIL free_run_flush got=%b exp=0", flush); end
      next_pc = 32'(i + 1);
      tick();
    end
    next_pc = 32'd5;
    tick();
    $display("test_free_run: pc=%h", pc);
  endtask

  task automatic test_redirect();
    checks++; if (pc !== 32'd5) begin failures++; $display("FAIL redirect_start got=%h exp=5", pc); end
    redirect = 1'b1; next_pc = 32'h40; tick(); redirect = 1'b0;
    checks++; if (pc !== 32'h40) begin failures++; $display("FAIL redirect_pc got=%h exp=40", pc); end
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL redirect_flush got=%b exp=1", flush); end
    next_pc = 32'h41; tick();
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL redirect_flush_drop got=%b exp=0", flush); end
    checks++; if (pc !== 32'h41) begin failures++; $display("FAIL redirect_seq got=%h exp=41", pc); end
    $display("test_redirect: pc=%h", pc);
  endtask

  task automatic test_irq_priority();
    redirect = 1'b1; next_pc = 32'h0F; tick(); redirect = 1'b0;
    irq = 3'b110; next_pc = 32'h10; tick();
    checks++; if (pc !== 32'h10 || int_ack !== 3'b000) begin failures++; $display("FAIL irq_pend_wait pc=%h ack=%b exp pc=10 ack=000", pc, int_ack); end
    next_pc = 32'h11; tick();
    checks++; if (pc !== VEC1) begin failures++; $display("FAIL irq_vec1 got=%h exp=%h", pc, VEC1); end
    checks++; if (int_ack !== 3'b010) begin failures++; $display("FAIL irq_ack1 got=%b exp=010", int_ack); end
    checks++; if (flush !== 1'b1 || in_service !== 1'b1) begin failures++; $display("FAIL irq_enter flush=%b in_service=%b exp=1,1", flush, in_service); end
    next_pc = VEC1 + 1; tick();
    checks++; if (pc !== VEC1 + 1 || int_ack !== 3'b000) begin failures++; $display("FAIL irq_masked pc=%h ack=%b exp pc=%h ack=000", pc, int_ack, VEC1 + 1); end
    eret = 1'b1; next_pc = VEC1 + 2; tick(); eret = 1'b0;
    checks++; if (pc !== 32'h11) begin failures++; $display("FAIL eret_pc got=%h exp=11", pc); end
    checks++; if (in_service !== 1'b0 || flush !== 1'b1) begin failures++; $display("FAIL eret_flags in_service=%b flush=%b exp=0,1", in_service, flush); end
    next_pc = 32'h12; tick();
    checks++; if (pc !== VEC2 || int_ack !== 3'b100) begin failures++; $display("FAIL irq_vec2 pc=%h ack=%b exp pc=%h ack=100", pc, int_ack, VEC2); end
    eret = 1'b1; next_pc = VEC2 + 1; tick(); eret = 1'b0;
    checks++; if (pc !== 32'h12) begin failures++; $display("FAIL eret2_pc got=%h exp=12", pc); end
    irq = 3'b000;
    $display("test_irq_priority: pc=%h", pc);
  endtask

  task automatic test_stall_irq();
    stall = 1'b1; irq = 3'b001; next_pc = 32'h13;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc !== 32'h12 || int_ack !== 3'b000) begin failures++; $display("FAIL stall_hold cyc=%0d pc=%h ack=%b exp pc=12 ack=000", i, pc, int_ack); end
    end
    stall = 1'b0; tick();
    checks++; if (pc !== VEC0 || int_ack !== 3'b001) begin failures++; $display("FAIL stall_vec0 pc=%h ack=%b exp pc=%h ack=001", pc, int_ack, VEC0); end
    eret = 1'b1; next_pc = VEC0 + 1; tick(); eret = 1'b0;
    checks++; if (pc !== 32'h13) begin failures++; $display("FAIL stall_eret got=%h exp=13", pc); end
    irq = 3'b000;
    $display("test_stall_irq: pc=%h", pc);
  endtask

  task automatic test_halt_go();
    redirect = 1'b1; next_pc = 32'h8; tick(); redirect = 1'b0;
    halt = 1'b1; next_pc = 32'h9; tick(); halt = 1'b0;
    checks++; if (pc !== 32'h9 || halted !== 1'b1) begin failures++; $display("FAIL halt_enter pc=%h halted=%b exp pc=9 halted=1", pc, halted); end
    next_pc = 32'hDEAD; irq = 3'b010;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (pc !== 32'h9 || halted !== 1'b1 || int_ack !== 3'b000) begin failures++; $display("FAIL halt_hold cyc=%0d pc=%h halted=%b ack=%b exp pc=9 halted=1 ack=000", i, pc, halted, int_ack); end
    end
    go = 1'b1; tick(); go = 1'b0;
    checks++; if (pc !== 32'h9 || halted !== 1'b0) begin failures++; $display("FAIL halt_go pc=%h halted=%b exp pc=9 halted=0", pc, halted); end
    next_pc = 32'hA; tick();
    checks++; if (pc !== VEC1 || int_ack !== 3'b010) begin failures++; $display("FAIL halt_pend_vec pc=%h ack=%b exp pc=%h ack=010", pc, int_ack, VEC1); end
    eret = 1'b1; next_pc = VEC1 + 1; tick(); eret = 1'b0; irq = 3'b000;
    checks++; if (pc !== 32'hA) begin failures++; $display("FAIL halt_eret got=%h exp=a", pc); end
    halt = 1'b1; next_pc = 32'hB; tick();
    checks++; if (halted !== 1'b1 || pc !== 32'hB) begin failures++; $display("FAIL halt2_enter pc=%h halted=%b exp pc=b halted=1", pc, halted); end
    go = 1'b1; next_pc = 32'h55; tick(); halt = 1'b0; go = 1'b0;
    checks++; if (halted !== 1'b0 || pc !== 32'hB) begin failures++; $display("FAIL halt_go_both pc=%h halted=%b exp pc=b halted=0", pc, halted); end
    next_pc = 32'hC; tick();
    checks++; if (pc !== 32'hC || halted !== 1'b0) begin failures++; $display("FAIL halt_resume pc=%h halted=%b exp pc=c halted=0", pc, halted); end
    $display("test_halt_go: pc=%h", pc);
  endtask

  task automatic test_nesting();
    redirect = 1'b1; next_pc = 32'h20; tick(); redirect = 1'b0;
    irq = 3'b100; next_pc = 32'h21; tick();
    next_pc = 32'h22; tick();
    checks++; if (pc !== VEC2 || int_ack !== 3'b100) begin failures++; $display("FAIL nest_vec2 pc=%h ack=%b exp pc=%h ack=100", pc, int_ack, VEC2); end
    irq = 3'b101; next_pc = VEC2 + 1; tick();
    next_pc = VEC2 + 2; tick();
`ifdef PC_SEQ_INT_NEST_EN
    checks++; if (pc !== VEC0 || int_ack !== 3'b001) begin failures++; $display("FAIL nest_preempt pc=%h ack=%b exp pc=%h ack=001", pc, int_ack, VEC0); end
    eret = 1'b1; next_pc = VEC0 + 1; tick();
    checks++; if (pc !== VEC2 + 2 || in_service !== 1'b1) begin failures++; $display("FAIL nest_eret1 pc=%h in_service=%b exp pc=%h in_service=1", pc, in_service, VEC2 + 2); end
    next_pc = VEC2 + 3; tick(); eret = 1'b0;
    checks++; if (pc !== 32'h22 || in_service !== 1'b0) begin failures++; $display("FAIL nest_eret2 pc=%h in_service=%b exp pc=22 in_service=0", pc, in_service); end
`else
    checks++; if (pc !== VEC2 + 2 || int_ack !== 3'b000) begin failures++; $display("FAIL nest_masked pc=%h ack=%b exp pc=%h ack=000", pc, int_ack, VEC2 + 2); end
    eret = 1'b1; next_pc = VEC2 + 3; tick(); eret = 1'b0;
    checks++; if (pc !== 32'h22 || in_service !== 1'b0) begin failures++; $display("FAIL nest_eret pc=%h in_service=%b exp pc=22 in_service=0", pc, in_service); end
    next_pc = 32'h23; tick();
    checks++; if (pc !== VEC0 || int_ack !== 3'b001) begin failures++; $display("FAIL nest_late_vec0 pc=%h ack=%b exp pc=%h ack=001", pc, int_ack, VEC0); end
    eret = 1'b1; next_pc = VEC0 + 1; tick(); eret = 1'b0;
    checks++; if (pc !== 32'h23) begin failures++; $display("FAIL nest_late_eret got=%h exp=23", pc); end
`endif
    irq = 3'b000;
    $display("test_nesting: pc=%h", pc);
  endtask

  task automatic test_random();
    int errs_before;
    errs_before = failures;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 199) == 0);
      stall    = ($urandom_range(0, 4) == 0);
      halt     = ($urandom_range(0, 39) == 0);
      go       = ($urandom_range(0, 3) == 0);
      eret     = ($urandom_range(0, 5) == 0);
      redirect = ($urandom_range(0, 3) == 0);
      next_pc  = redirect ? 32'($urandom) : m_pc + 32'd1;
      for (int b = 0; b < 3; b++) if ($urandom_range(0, 11) == 0) irq[b] = ~irq[b];
      tick();
      checks++; if (pc !== m_pc) begin failures++; if (failures < 30) $display("FAIL rand_pc cyc=%0d got=%h exp=%h", n, pc, m_pc); end
      checks++; if (flush !== m_flush) begin failures++; if (failures < 30) $display("FAIL rand_flush cyc=%0d got=%b exp=%b", n, flush, m_flush); end
      checks++; if (int_ack !== m_ack) begin failures++; if (failures < 30) $display("FAIL rand_ack cyc=%0d got=%b exp=%b", n, int_ack, m_ack); end
      checks++; if (in_service !== (m_epc.size() != 0)) begin failures++; if (failures < 30) $display("FAIL rand_in_service cyc=%0d got=%b exp=%b", n, in_service, m_epc.size() != 0); end
      checks++; if (halted !== (m_mode == M_HALT)) begin failures++; if (failures < 30) $display("FAIL rand_halted cyc=%0d got=%b exp=%b", n, halted, m_mode == M_HALT); end
    end
    rst = 1'b0; stall = 1'b0; halt = 1'b0; go = 1'b0; eret = 1'b0; redirect = 1'b0; irq = 3'b000;
    $display("test_random: cycles=3000 new_errors=%0d", failures - errs_before);
  endtask

  initial begin
    m_pc = RESET_PC; m_mode = M_RUN; m_ret = M_RUN;
    m_pend = 3'b000; m_irq_q = 3'b000; m_ack = 3'b000; m_flush = 1'b0;
    #2;
    test_reset();
    test_free_run();
    test_redirect();
    test_irq_priority();
    test_stall_irq();
    test_halt_go();
    test_nesting();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
